// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
//   NOP           - instruction shown on decode outputs when the queue is empty
//   ROM_AW        - ROM word address width
//   fetch_state_t - sequencer FSM states
//   fetch_entry_t - one queue entry: an instruction pair plus its PC
package fetch_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          ROM_AW = 10;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic        slot1_ok;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch -> decode instruction-pair channel.
//   dec_valid       - head of the fetch queue holds a pair
//   dec_ready       - decode accepts the head on this rising edge
//   dec_pc          - PC of slot 0
//   dec_instr0/1    - instructions at dec_pc and dec_pc+4
//   dec_slot1_valid - slot 1 instruction is usable
// Handshake: a pair transfers on every rising edge where dec_valid and
// dec_ready are both 1. dec_valid does not depend on dec_ready, and the
// payload is stable while dec_valid=1 and dec_ready=0 (a redirect or reset
// may still withdraw it).
interface fetch_ctrl_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr0;
  logic [31:0] dec_instr1;
  logic        dec_slot1_valid;

  modport master (
    output dec_valid, dec_pc, dec_instr0, dec_instr1, dec_slot1_valid,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_pc, dec_instr0, dec_instr1, dec_slot1_valid,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of DEPTH instruction-pair entries.
//   push/push_data - write an entry (dropped if full and not popping)
//   pop            - remove the head (ignored when empty)
//   flush          - empty the queue; overrides push and pop
//   head           - current head entry (meaningful only when count != 0)
//   count          - number of stored entries, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          pop_eff;
  logic          push_eff;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_eff  = pop && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    push_eff = push && ((count_q != (PW+1)'(DEPTH)) || pop_eff);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(push_eff) - (PW+1)'(pop_eff);
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: dual-issue fetch sequencer between instruction ROM and decode.
//   clk, rst_n         - clock, asynchronous active-low reset
//   rom_addr           - ROM word address (pc[11:2]), from the PC register
//   rom_instr1/2       - ROM words rom_addr / rom_addr+1, valid the cycle after sampling
//   redirect_valid/pc  - load a new PC (bits [1:0] ignored), flushes stale fetches
//   halt               - stop issuing fetches
//   dec                - decode channel (fetch_ctrl_if master)
//   halted             - FSM is in HALT
//   dbg_state          - current FSM state, for observation
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  fetch_ctrl_if.master      dec,
  output logic              halted,
  output fetch_state_t      dbg_state
);

  localparam int PW = $clog2(DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  fetch_entry_t q_head;
  fetch_entry_t q_push_data;
  logic [PW:0]  q_count;
  logic         q_push;
  logic         q_pop;
  logic         pop;
  logic [PW+1:0] credit_used;
  logic         credit_ok;
  logic         issue;

  assign dec.dec_valid = (q_count != '0);
  assign pop           = dec.dec_valid && dec.dec_ready;

  // Queue slots already spoken for after this edge: stored pairs plus the
  // returning read, minus the pair leaving now. A new fetch needs a free one.
  assign credit_used = {1'b0, q_count} + (PW+2)'(inflight_q) - (PW+2)'(pop);
  assign credit_ok   = credit_used < (PW+2)'(DEPTH);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    issue         = 1'b0;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (halt) state_d = ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
      issue = (state_q != ST_HALT) && !halt && credit_ok;
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd8;
      end
    end
  end

  // The response to last edge's fetch is on the ROM outputs now; a redirect
  // makes it stale, so it is dropped together with the flush.
  always_comb begin
    q_push      = inflight_q && !redirect_valid;
    q_pop       = pop && !redirect_valid;
    q_push_data = '{pc:       inflight_pc_q,
                    instr0:   rom_instr1,
                    instr1:   rom_instr2,
                    slot1_ok: (inflight_pc_q[11:2] != 10'h3FF)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count)
  );

  assign dec.dec_pc          = dec.dec_valid ? q_head.pc       : 32'h0;
  assign dec.dec_instr0      = dec.dec_valid ? q_head.instr0   : NOP;
  assign dec.dec_instr1      = dec.dec_valid ? q_head.instr1   : NOP;
  assign dec.dec_slot1_valid = dec.dec_valid && q_head.slot1_ok;

  assign rom_addr  = pc_q[11:2];
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed testbench for fetch_ctrl with a synchronous ROM model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [9:0]   rom_addr;
  logic [31:0]  rom_instr1;
  logic [31:0]  rom_instr2;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         halt;
  logic         halted;
  fetch_state_t dbg_state;

  fetch_ctrl_if dec_if ();

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr1     (rom_instr1),
    .rom_instr2     (rom_instr2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec            (dec_if),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ROM model: each word holds a recognisable tag plus its own address.
  function automatic logic [31:0] rom_word(input logic [9:0] w);
    return {16'hC0DE, 6'd0, w};
  endfunction

  always @(posedge clk) begin
    rom_instr1 <= rom_word(rom_addr);
    rom_instr2 <= rom_word(rom_addr + 10'd1);
  end

  // driver / checking tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(dec_if.dec_valid),       32'd0);
    check({tag, "_halted"}, 32'(halted),                 32'd0);
    check({tag, "_rom"},    32'(rom_addr),               32'd0);
    check({tag, "_pc"},     dec_if.dec_pc,               32'd0);
    check({tag, "_i0"},     dec_if.dec_instr0,           NOP);
    check({tag, "_i1"},     dec_if.dec_instr1,           NOP);
    check({tag, "_s1"},     32'(dec_if.dec_slot1_valid), 32'd0);
    check({tag, "_state"},  32'(dbg_state),              32'(ST_BOOT));
  endtask

  initial begin
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    halt             = 1'b0;
    dec_if.dec_ready = 1'b1;
    #2;
    check_reset_outputs("rst");
    #10;
    rst_n = 1'b1;

    // boot: first fetch at E0, first pair visible after E1
    tick();
    check("e0_valid", 32'(dec_if.dec_valid), 32'd0);
    check("e0_rom",   32'(rom_addr),         32'd2);
    tick();
    check("e1_valid", 32'(dec_if.dec_valid),       32'd1);
    check("e1_pc",    dec_if.dec_pc,               32'h0);
    check("e1_i0",    dec_if.dec_instr0,           rom_word(10'd0));
    check("e1_i1",    dec_if.dec_instr1,           rom_word(10'd1));
    check("e1_s1",    32'(dec_if.dec_slot1_valid), 32'd1);
    check("e1_rom",   32'(rom_addr),               32'd4);

    // steady streaming: one pair per cycle
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("stream_pc",  dec_if.dec_pc,     32'(8 * k));
      check("stream_i0",  dec_if.dec_instr0, rom_word(10'(2 * k)));
      check("stream_i1",  dec_if.dec_instr1, rom_word(10'(2 * k + 1)));
      check("stream_rom", 32'(rom_addr),     32'(2 * k + 4));
    end

    // back-pressure: queue fills to 4 pairs (40..64), PC freezes at 72
    dec_if.dec_ready = 1'b0;
    repeat (10) tick();
    check("stall_valid", 32'(dec_if.dec_valid), 32'd1);
    check("stall_pc",    dec_if.dec_pc,         32'd40);
    check("stall_rom",   32'(rom_addr),         32'd18);

    // release: consecutive pairs, nothing lost or repeated
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(48 + 8 * i));
    dec_if.dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("drain_pc", dec_if.dec_pc, exp_q.pop_front());
    end

    // redirect to 0x50 with credits exhausted and a fetch in flight
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0050;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(dec_if.dec_valid), 32'd0);
    check("redir_rom",         32'(rom_addr),         32'h14);
    tick();
    check("redir_r1_valid",    32'(dec_if.dec_valid), 32'd0);
    tick();
    check("redir_r2_valid",    32'(dec_if.dec_valid), 32'd1);
    check("redir_r2_pc",       dec_if.dec_pc,         32'h50);
    check("redir_r2_i0",       dec_if.dec_instr0,     rom_word(10'h14));
    tick();
    check("redir_r3_pc",       dec_if.dec_pc,         32'h58);

    // redirect to the last ROM word pair (bits [1:0] must be ignored)
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFF;
    tick();
    redirect_valid = 1'b0;
    check("ffc_rom0",  32'(rom_addr), 32'h3FF);
    tick();
    check("ffc_rom1",  32'(rom_addr),         32'd1);
    check("ffc_valid", 32'(dec_if.dec_valid), 32'd0);
    tick();
    check("ffc_pc",    dec_if.dec_pc,               32'hFFC);
    check("ffc_s1",    32'(dec_if.dec_slot1_valid), 32'd0);
    check("ffc_i0",    dec_if.dec_instr0,           rom_word(10'h3FF));
    tick();
    check("wrap_pc",   dec_if.dec_pc,               32'h1004);
    check("wrap_s1",   32'(dec_if.dec_slot1_valid), 32'd1);
    check("wrap_i0",   dec_if.dec_instr0,           rom_word(10'd1));

    // halt mid-stream: in-flight pair 0x100C still delivered, then nothing
    halt = 1'b1;
    tick();
    check("halt_halted", 32'(halted),         32'd1);
    check("halt_state",  32'(dbg_state),      32'(ST_HALT));
    check("halt_pc",     dec_if.dec_pc,       32'h100C);
    check("halt_rom",    32'(rom_addr),       32'd5);
    tick();
    check("halt_empty",  32'(dec_if.dec_valid), 32'd0);
    repeat (3) tick();
    check("halt_idle_valid", 32'(dec_if.dec_valid), 32'd0);
    check("halt_idle_rom",   32'(rom_addr),         32'd5);
    check("halt_idle_hlt",   32'(halted),           32'd1);

    // resume via redirect to 0x20
    halt           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    tick();
    check("resume_r1_valid", 32'(dec_if.dec_valid), 32'd0);
    tick();
    check("resume_pc",  dec_if.dec_pc,     32'h20);
    check("resume_i0",  dec_if.dec_instr0, rom_word(10'd8));
    tick();
    check("resume_pc2", dec_if.dec_pc,     32'h28);

    // asynchronous reset while halted with a pair queued
    halt = 1'b1;
    tick();
    check("pre_rst_halted", 32'(halted),         32'd1);
    check("pre_rst_pc",     dec_if.dec_pc,       32'h30);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    halt = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("reboot_valid", 32'(dec_if.dec_valid), 32'd1);
    check("reboot_pc",    dec_if.dec_pc,         32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
